// File: rtl/tick_stretch_pkg.sv
// tick_stretch_pkg: shared FSM encoding and counter width helper for tick_stretch.
package tick_stretch_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sat_updown_cnt.sv
// sat_updown_cnt: saturating up/down event counter for queued ticks.
//   clk, rst_n (sync, active-low); inc/dec requests; count output;
//   sat_drop flags an inc refused because count is already at MAX.
module sat_updown_cnt
  import tick_stretch_pkg::*;
#(
  parameter int MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inc,
  input  logic                       dec,
  output logic [cnt_w(MAX+1)-1:0]    count,
  output logic                       sat_drop
);
  localparam int W = cnt_w(MAX+1);
  localparam logic [W-1:0] MAX_V = W'(MAX);
  logic [W-1:0] count_q, count_d;
  always_comb begin
    sat_drop = inc && !dec && (count_q == MAX_V);
    count_d  = (inc && !dec && !sat_drop) ? count_q + W'(1) :
               (dec && !inc && count_q != '0) ? count_q - W'(1) : count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/tick_stretch.sv
// tick_stretch: stretch single-cycle ticks into HIGH_CYCLES pulses with GAP_CYCLES low gaps.
//   clk, rst_n (sync, active-low); tick input event.
//   level: stretched pulse; busy: pulse or gap in progress; pend_cnt: queued ticks;
//   overflow: one-cycle flag for a dropped tick. All outputs registered.
//   TICK_STRETCH_RETRIGGER_EN: a tick during the high phase extends the pulse instead of queueing.
module tick_stretch
  import tick_stretch_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_DEPTH  = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tick,
  output logic                             level,
  output logic                             busy,
  output logic [cnt_w(PEND_DEPTH+1)-1:0]   pend_cnt,
  output logic                             overflow
);
  localparam int CW = cnt_w(HIGH_CYCLES > GAP_CYCLES ? HIGH_CYCLES : GAP_CYCLES);
  localparam logic [CW-1:0] HI_LD  = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d, busy_q, busy_d, overflow_q;
  logic          has_pend, last_gap, retrig, inc, dec, sat_drop;
  always_comb begin
    has_pend = pend_cnt != '0;
    last_gap = (state_q == ST_GAP) && (cnt_q == '0);
`ifdef TICK_STRETCH_RETRIGGER_EN
    retrig = tick && (state_q == ST_HIGH);
`else
    retrig = 1'b0;
`endif
    // A last-gap tick with an empty queue starts the next pulse directly;
    // otherwise it joins the queue while the oldest queued event is consumed.
    inc = tick && (((state_q == ST_HIGH) && !retrig) || ((state_q == ST_GAP) && !(last_gap && !has_pend)));
    dec = last_gap && has_pend;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (tick) begin
        state_d = ST_HIGH;
        cnt_d   = HI_LD;
      end
    end else if (state_q == ST_HIGH) begin
      if (retrig) cnt_d = HI_LD;
      else if (cnt_q == '0) begin
        state_d = ST_GAP;
        cnt_d   = GAP_LD;
      end else cnt_d = cnt_q - CW'(1);
    end else if (state_q == ST_GAP) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      else if (has_pend || tick) begin
        state_d = ST_HIGH;
        cnt_d   = HI_LD;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
    level_d = state_d == ST_HIGH;
    busy_d  = state_d != ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      busy_q     <= busy_d;
      overflow_q <= sat_drop;
    end
  end
  sat_updown_cnt #(.MAX(PEND_DEPTH)) u_pend (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc),
    .dec      (dec),
    .count    (pend_cnt),
    .sat_drop (sat_drop)
  );
  assign level    = level_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_tick_stretch.sv
// tb_tick_stretch: directed and randomized checks of tick_stretch against an interval model.
module tb_tick_stretch;
  localparam int H = 4;
  localparam int G = 2;
  localparam int D = 3;
`ifdef TICK_STRETCH_RETRIGGER_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       level, busy, overflow;
  logic [1:0] pend_cnt;
  int n_pass = 0;
  int n_tot  = 0;
  // model: current/most recent pulse occupies [cs, ce), its gap [ce, ce+G)
  int mc = 0;
  int cs = -100;
  int ce = -100;
  int mp = 0;
  bit movf = 1'b0;
  bit bz, lg, st;
  int dens = 30;

  tick_stretch #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .level    (level),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  // Compare DUT to model every cycle, then advance the model with this cycle's inputs.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("level", level, 32'(cs <= mc && mc < ce));
      chk("busy", busy, 32'(cs <= mc && mc < ce + G));
      chk("pend_cnt", pend_cnt, 32'(mp));
      chk("overflow", overflow, 32'(movf));
      movf = 1'b0;
      if (!rst_n) begin
        cs = -100;
        ce = -100;
        mp = 0;
      end else begin
        bz = cs <= mc && mc < ce + G;
        lg = bz && mc == ce + G - 1;
        st = 1'b0;
        if (tick) begin
          if (!bz || (lg && mp == 0)) begin
            cs = mc + 1;
            ce = mc + 1 + H;
            st = 1'b1;
          end else if (RT && mc < ce) ce = mc + 1 + H;
          else if (mp == D && !lg) movf = 1'b1;
          else mp++;
        end
        if (!st && lg && mp > 0) begin
          mp--;
          cs = mc + 1;
          ce = mc + 1 + H;
        end
      end
      mc++;
    end
  end

  task automatic lit(input int id, input int r);
    case (id)
      1: case (r)
        10: chk("s1_level@10", level, 0);
        11: chk("s1_level@11", level, 1);
        14: chk("s1_level@14", level, 1);
        15: begin chk("s1_level@15", level, 0); chk("s1_busy@15", busy, 1); end
        16: chk("s1_busy@16", busy, 1);
        17: chk("s1_busy@17", busy, 0);
        default: ;
      endcase
      2: case (r)
        12: chk("s2_pend@12", pend_cnt, 1);
        16: begin chk("s2_pend@16", pend_cnt, 1); chk("s2_level@16", level, 0); end
        17: begin chk("s2_pend@17", pend_cnt, 0); chk("s2_level@17", level, 1); end
        20: chk("s2_level@20", level, 1);
        21: chk("s2_level@21", level, 0);
        default: ;
      endcase
      3: case (r)
        14: begin chk("s3_pend@14", pend_cnt, 3); chk("s3_ovf@14", overflow, 0); end
        15: begin chk("s3_ovf@15", overflow, 1); chk("s3_pend@15", pend_cnt, 3); end
        16: chk("s3_ovf@16", overflow, 0);
        17: chk("s3_pend@17", pend_cnt, 2);
        23: chk("s3_level@23", level, 1);
        29: chk("s3_level@29", level, 1);
        33: chk("s3_level@33", level, 0);
        35: chk("s3_busy@35", busy, 0);
        default: ;
      endcase
      4: case (r)
        16: chk("s4_pend@16", pend_cnt, 0);
        17: begin chk("s4_level@17", level, 1); chk("s4_pend@17", pend_cnt, 0); end
        20: chk("s4_level@20", level, 1);
        21: chk("s4_level@21", level, 0);
        default: ;
      endcase
      5: case (r)
        13: chk("s5_pend@13", pend_cnt, 1);
        14: begin chk("s5_level@14", level, 0); chk("s5_busy@14", busy, 0); chk("s5_pend@14", pend_cnt, 0); end
        17: chk("s5_level@17", level, 0);
        default: ;
      endcase
      6: case (r)
        13: chk("s6_pend@13", pend_cnt, 0);
        16: chk("s6_level@16", level, 1);
        17: chk("s6_level@17", level, 0);
        18: chk("s6_busy@18", busy, 1);
        19: chk("s6_busy@19", busy, 0);
        default: ;
      endcase
      default: ;
    endcase
  endtask

  task automatic scn(input int id, input logic [63:0] m, input int rst_at);
    rst_n = 1'b0;
    tick  = 1'b0;
    for (int r = -1; r < 45; r++) begin
      @(posedge clk);
      #1;
      if (r >= 0) lit(id, r);
      rst_n = r != rst_at && r >= 0;
      tick  = r >= 0 && m[r];
    end
  endtask

  initial begin
    scn(1, 64'h1 << 10, -1);
`ifdef TICK_STRETCH_RETRIGGER_EN
    scn(6, (64'h1 << 10) | (64'h1 << 12), -1);
`else
    scn(2, 64'h3 << 10, -1);
    scn(3, 64'h1F << 10, -1);
    scn(4, (64'h1 << 10) | (64'h1 << 16), -1);
    scn(5, 64'h3 << 10, 13);
`endif
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (i % 250 == 0) dens = $urandom_range(5, 90);
      tick  = $urandom_range(0, 99) < dens;
      rst_n = $urandom_range(0, 299) != 0;
    end
    tick  = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
